// File: rtl/mem_lsu_if.sv
// Bundle between the MEM stage, the load/store unit and the word-organised data memory.
// The master modport is the LSU's view; slave is the pipeline and memory side.
interface mem_lsu_if;
    localparam int unsigned XLEN = 32;

    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [XLEN-1:0] req_pc;

    logic            mem_valid;
    logic            mem_ready;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_byte_select;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic [1:0]      resp_exc;
    logic [XLEN-1:0] resp_pc;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_pc,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_byte_select, mem_wdata,
        output resp_valid, resp_data, resp_exc, resp_pc
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_pc,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_byte_select, mem_wdata,
        input  resp_valid, resp_data, resp_exc, resp_pc
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator: alignment check, lane steering for stores, load extraction
// and sign/zero extension, with a per-access timeout watchdog.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic      clk,
    input  logic      reset,
    mem_lsu_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_BYTE     = 2'b00;
    localparam logic [1:0] SZ_HALF     = 2'b01;
    localparam logic [1:0] EXC_OK      = 2'b00;
    localparam logic [1:0] EXC_LD_MIS  = 2'b01;
    localparam logic [1:0] EXC_ST_MIS  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_ready_q, req_ready_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]        mem_bsel_q, mem_bsel_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic [1:0]        resp_exc_q, resp_exc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            default: misaligned = (lane != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_sel = 4'b0001 << lane;
            SZ_HALF: byte_sel = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        case (size)
            SZ_BYTE: lane_wdata = {4{wdata[7:0]}};
            SZ_HALF: lane_wdata = {2{wdata[15:0]}};
            default: lane_wdata = wdata;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [1:0] size, input logic uns,
                                                     input logic [1:0] lane, input logic [XLEN-1:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extract = rdata;
        endcase
    endfunction

    // Next state, latched request fields, response payload and registered output values.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_exc_d  = resp_exc_q;
        resp_pc_d   = resp_pc_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    pc_d    = bus.req_pc;
                    cnt_d   = '0;
                    if (misaligned(bus.req_op[1:0], bus.req_addr[1:0])) begin
                        state_d     = RESP;
                        resp_exc_d  = bus.req_op[3] ? EXC_ST_MIS : EXC_LD_MIS;
                        resp_data_d = '0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_ready) begin
                    if (op_q[3]) begin
                        state_d     = RESP;
                        resp_exc_d  = EXC_OK;
                        resp_data_d = '0;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    state_d     = RESP;
                    resp_exc_d  = EXC_TIMEOUT;
                    resp_data_d = '0;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_rvalid) begin
                    state_d     = RESP;
                    resp_exc_d  = EXC_OK;
                    resp_data_d = load_extract(op_q[1:0], op_q[2], addr_q[1:0], bus.mem_rdata);
                end else if (cnt_q >= CNT_LAST) begin
                    state_d     = RESP;
                    resp_exc_d  = EXC_TIMEOUT;
                    resp_data_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == RESP && state_q != RESP) begin
            resp_pc_d = pc_d;
        end

        // Outputs are registered, so they are decoded from the state being entered.
        req_ready_d  = (state_d == IDLE);
        mem_valid_d  = (state_d == ISSUE);
        mem_we_d     = mem_valid_d && op_d[3];
        mem_addr_d   = mem_valid_d ? {addr_d[31:2], 2'b00} : '0;
        mem_bsel_d   = mem_we_d ? byte_sel(op_d[1:0], addr_d[1:0]) : 4'b0000;
        mem_wdata_d  = mem_we_d ? lane_wdata(op_d[1:0], wdata_d) : '0;
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pc_q         <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_bsel_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_exc_q   <= '0;
            resp_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_bsel_q   <= mem_bsel_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_exc_q   <= resp_exc_d;
            resp_pc_q    <= resp_pc_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.mem_valid       = mem_valid_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_byte_select = mem_bsel_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_data       = resp_data_q;
    assign bus.resp_exc        = resp_exc_q;
    assign bus.resp_pc         = resp_pc_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a transaction-level reference model checked every cycle on two
// instances (default watchdog and a 4-cycle watchdog), plus literal expectations.
module tb_mem_lsu;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_lsu_if bus_a ();
    mem_lsu_if bus_t ();

    mem_lsu #(.TIMEOUT_CYCLES(255)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mem_lsu #(.TIMEOUT_CYCLES(4))   dut_t (.clk(clk), .reset(reset), .bus(bus_t));

    localparam int P_IDLE = 0;
    localparam int P_MEM  = 1;
    localparam int P_DATA = 2;
    localparam int P_RESP = 3;

    int          limit [2] = '{255, 4};
    int          ph    [2];
    int          age   [2];
    logic [3:0]  m_op  [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdat[2];
    logic [31:0] m_pc  [2];
    logic [31:0] e_data[2];
    logic [1:0]  e_exc [2];
    logic [31:0] e_pc  [2];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] exp_bsel(input logic [1:0] sz, input logic [31:0] addr);
        int n = nbytes(sz);
        int m = ((1 << n) - 1) << int'(addr[1:0]);
        return 4'(m);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        if (n == 1) return (wd & 32'hFF) * 32'h01010101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int n = nbytes(op[1:0]);
        logic [31:0] mask;
        logic [31:0] v;
        if (n == 4) return rdata;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rdata >> (8 * int'(addr[1:0]))) & mask;
        if (!op[2] && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_reset(input int k);
        ph[k] = P_IDLE; age[k] = 0;
        m_op[k] = '0; m_addr[k] = '0; m_wdat[k] = '0; m_pc[k] = '0;
        e_data[k] = '0; e_exc[k] = '0; e_pc[k] = '0;
    endtask

    task automatic finish_txn(input int k, input logic [1:0] exc, input logic [31:0] data);
        ph[k] = P_RESP; e_exc[k] = exc; e_data[k] = data; e_pc[k] = m_pc[k];
    endtask

    // One access at a time; the watchdog bounds the total cycles spent talking to memory.
    task automatic model_step(input int k, input logic v, input logic [3:0] op,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                              input logic mrdy, input logic rvld, input logic [31:0] rdata);
        case (ph[k])
            P_IDLE: if (v) begin
                m_op[k] = op; m_addr[k] = addr; m_wdat[k] = wd; m_pc[k] = pc; age[k] = 0;
                if (int'(addr[1:0]) % nbytes(op[1:0]) != 0)
                    finish_txn(k, op[3] ? 2'b10 : 2'b01, 32'd0);
                else
                    ph[k] = P_MEM;
            end
            P_MEM: begin
                if (mrdy) begin
                    if (m_op[k][3]) finish_txn(k, 2'b00, 32'd0);
                    else ph[k] = P_DATA;
                end else if (age[k] >= limit[k] - 1) finish_txn(k, 2'b11, 32'd0);
                age[k]++;
            end
            P_DATA: begin
                if (rvld) finish_txn(k, 2'b00, exp_load(m_op[k], m_addr[k], rdata));
                else if (age[k] >= limit[k] - 1) finish_txn(k, 2'b11, 32'd0);
                age[k]++;
            end
            default: ph[k] = P_IDLE;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, bus_a.req_valid, bus_a.req_op, bus_a.req_addr, bus_a.req_wdata, bus_a.req_pc,
                       bus_a.mem_ready, bus_a.mem_rvalid, bus_a.mem_rdata);
            model_step(1, bus_t.req_valid, bus_t.req_op, bus_t.req_addr, bus_t.req_wdata, bus_t.req_pc,
                       bus_t.mem_ready, bus_t.mem_rvalid, bus_t.mem_rdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic rr, input logic mv, input logic we,
                       input logic [31:0] ma, input logic [3:0] bs, input logic [31:0] wd,
                       input logic rv, input logic [31:0] rd, input logic [1:0] re, input logic [31:0] rp);
        logic st;
        st = m_op[k][3];
        chk($sformatf("req_ready[%0d]", k), 32'(rr), 32'(ph[k] == P_IDLE));
        chk($sformatf("mem_valid[%0d]", k), 32'(mv), 32'(ph[k] == P_MEM));
        chk($sformatf("resp_valid[%0d]", k), 32'(rv), 32'(ph[k] == P_RESP));
        chk($sformatf("resp_data[%0d]", k), rd, e_data[k]);
        chk($sformatf("resp_exc[%0d]", k), 32'(re), 32'(e_exc[k]));
        chk($sformatf("resp_pc[%0d]", k), rp, e_pc[k]);
        if (ph[k] == P_MEM) begin
            chk($sformatf("mem_we[%0d]", k), 32'(we), 32'(st));
            chk($sformatf("mem_addr[%0d]", k), ma, m_addr[k] & 32'hFFFF_FFFC);
            chk($sformatf("mem_bsel[%0d]", k), 32'(bs), st ? 32'(exp_bsel(m_op[k][1:0], m_addr[k])) : 32'd0);
            chk($sformatf("mem_wdata[%0d]", k), wd, st ? exp_wdata(m_op[k][1:0], m_wdat[k]) : 32'd0);
        end
    endtask

    always @(negedge clk) begin
        cmp(0, bus_a.req_ready, bus_a.mem_valid, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_byte_select,
            bus_a.mem_wdata, bus_a.resp_valid, bus_a.resp_data, bus_a.resp_exc, bus_a.resp_pc);
        cmp(1, bus_t.req_ready, bus_t.mem_valid, bus_t.mem_we, bus_t.mem_addr, bus_t.mem_byte_select,
            bus_t.mem_wdata, bus_t.resp_valid, bus_t.resp_data, bus_t.resp_exc, bus_t.resp_pc);
    end

    task automatic req_a(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
        bus_a.req_valid = 1'b1; bus_a.req_op = op; bus_a.req_addr = addr;
        bus_a.req_wdata = wd; bus_a.req_pc = pc;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
    endtask

    task automatic req_t(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] pc);
        bus_t.req_valid = 1'b1; bus_t.req_op = op; bus_t.req_addr = addr;
        bus_t.req_wdata = 32'd0; bus_t.req_pc = pc;
        @(negedge clk);
        bus_t.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.req_valid = 0; bus_a.req_op = 0; bus_a.req_addr = 0; bus_a.req_wdata = 0; bus_a.req_pc = 0;
        bus_a.mem_ready = 0; bus_a.mem_rvalid = 0; bus_a.mem_rdata = 0;
        bus_t.req_valid = 0; bus_t.req_op = 0; bus_t.req_addr = 0; bus_t.req_wdata = 0; bus_t.req_pc = 0;
        bus_t.mem_ready = 0; bus_t.mem_rvalid = 0; bus_t.mem_rdata = 0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
        chk("rst_mem_valid", 32'(bus_a.mem_valid), 32'd0);
        chk("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // store byte with immediate ready
        bus_a.mem_ready = 1'b1;
        req_a(4'b1000, 32'h6, 32'hAB, 32'h100);
        chk("sb_bsel", 32'(bus_a.mem_byte_select), 32'b0100);
        chk("sb_addr", bus_a.mem_addr, 32'h4);
        chk("sb_wdata", bus_a.mem_wdata, 32'hABABABAB);
        chk("sb_we", 32'(bus_a.mem_we), 32'd1);
        @(negedge clk);
        chk("sb_resp", 32'(bus_a.resp_valid), 32'd1);
        chk("sb_exc", 32'(bus_a.resp_exc), 32'd0);
        chk("sb_pc", bus_a.resp_pc, 32'h100);
        @(negedge clk);
        chk("sb_ready_after", 32'(bus_a.req_ready), 32'd1);

        // store half to upper lane
        req_a(4'b1001, 32'hE, 32'h12345678, 32'h104);
        chk("sh_bsel", 32'(bus_a.mem_byte_select), 32'b1100);
        chk("sh_wdata", bus_a.mem_wdata, 32'h56785678);
        repeat (2) @(negedge clk);

        // signed / unsigned half loads
        bus_a.mem_rdata = 32'h8001F00F;
        req_a(4'b0001, 32'h10, 32'h0, 32'h108);
        @(negedge clk); bus_a.mem_rvalid = 1'b1;
        @(negedge clk); bus_a.mem_rvalid = 1'b0;
        chk("lh_resp", 32'(bus_a.resp_valid), 32'd1);
        chk("lh_data", bus_a.resp_data, 32'hFFFFF00F);
        @(negedge clk);
        req_a(4'b0101, 32'h12, 32'h0, 32'h10C);
        @(negedge clk); bus_a.mem_rvalid = 1'b1;
        @(negedge clk); bus_a.mem_rvalid = 1'b0;
        chk("lhu_resp", 32'(bus_a.resp_valid), 32'd1);
        chk("lhu_data", bus_a.resp_data, 32'h00008001);
        @(negedge clk);

        // rvalid during the accept cycle is ignored; unsigned flag ignored for words
        req_a(4'b0110, 32'h20, 32'h0, 32'h110);
        bus_a.mem_rvalid = 1'b1; bus_a.mem_rdata = 32'h11111111;
        @(negedge clk); bus_a.mem_rvalid = 1'b0; bus_a.mem_rdata = 32'h82222222;
        chk("lw_early_rvalid", 32'(bus_a.resp_valid), 32'd0);
        @(negedge clk); bus_a.mem_rvalid = 1'b1;
        @(negedge clk); bus_a.mem_rvalid = 1'b0;
        chk("lw_resp", 32'(bus_a.resp_valid), 32'd1);
        chk("lw_data", bus_a.resp_data, 32'h82222222);
        @(negedge clk);

        // misaligned load and store
        bus_a.mem_ready = 1'b0;
        req_a(4'b0010, 32'hA, 32'h0, 32'h200);
        chk("mis_ld_resp", 32'(bus_a.resp_valid), 32'd1);
        chk("mis_ld_exc", 32'(bus_a.resp_exc), 32'b01);
        chk("mis_ld_memv", 32'(bus_a.mem_valid), 32'd0);
        @(negedge clk);
        req_a(4'b1001, 32'h1, 32'hFFFF, 32'h204);
        chk("mis_st_exc", 32'(bus_a.resp_exc), 32'b10);
        chk("mis_st_pc", bus_a.resp_pc, 32'h204);
        @(negedge clk);

        // backpressure: ready low for five cycles
        bus_a.mem_rdata = 32'hC3000000;
        req_a(4'b0100, 32'h3, 32'h0, 32'h300);
        for (int i = 0; i < 5; i++) begin
            chk("bp_memv", 32'(bus_a.mem_valid), 32'd1);
            chk("bp_addr", bus_a.mem_addr, 32'h0);
            @(negedge clk);
        end
        bus_a.mem_ready = 1'b1;
        @(negedge clk); bus_a.mem_ready = 1'b0; bus_a.mem_rvalid = 1'b1;
        @(negedge clk); bus_a.mem_rvalid = 1'b0;
        chk("bp_resp", 32'(bus_a.resp_valid), 32'd1);
        chk("bp_data", bus_a.resp_data, 32'h000000C3);
        @(negedge clk);

        // timeout with TIMEOUT_CYCLES=4
        req_t(4'b0000, 32'h0, 32'h400);
        for (int i = 0; i < 4; i++) begin
            chk("to_memv", 32'(bus_t.mem_valid), 32'd1);
            @(negedge clk);
        end
        chk("to_memv_low", 32'(bus_t.mem_valid), 32'd0);
        chk("to_resp", 32'(bus_t.resp_valid), 32'd1);
        chk("to_exc", 32'(bus_t.resp_exc), 32'b11);
        chk("to_data", bus_t.resp_data, 32'h0);
        @(negedge clk);
        chk("to_ready", 32'(bus_t.req_ready), 32'd1);

        // completion on the last permitted cycle beats the timeout
        bus_t.mem_rdata = 32'h00007F00;
        req_t(4'b0000, 32'h5, 32'h404);
        repeat (3) @(negedge clk);
        bus_t.mem_ready = 1'b1;
        @(negedge clk); bus_t.mem_ready = 1'b0; bus_t.mem_rvalid = 1'b1;
        @(negedge clk); bus_t.mem_rvalid = 1'b0;
        chk("cw_exc", 32'(bus_t.resp_exc), 32'b00);
        chk("cw_data", bus_t.resp_data, 32'h0000007F);
        @(negedge clk);

        // asynchronous reset while a store is being issued
        req_a(4'b1010, 32'h44, 32'hDEADBEEF, 32'h500);
        chk("rs_bsel", 32'(bus_a.mem_byte_select), 32'b1111);
        chk("rs_wdata", bus_a.mem_wdata, 32'hDEADBEEF);
        #2 reset = 1'b0;
        #1 chk("rs_memv_async", 32'(bus_a.mem_valid), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // asynchronous reset in WAIT_R; a late rvalid is ignored
        bus_a.mem_ready = 1'b1;
        req_a(4'b0010, 32'h40, 32'h0, 32'h600);
        @(negedge clk); bus_a.mem_ready = 1'b0;
        chk("rw_ready_busy", 32'(bus_a.req_ready), 32'd0);
        #2 reset = 1'b0;
        #1 chk("rw_ready_async", 32'(bus_a.req_ready), 32'd1);
        chk("rw_memv_async", 32'(bus_a.mem_valid), 32'd0);
        @(negedge clk); reset = 1'b1; bus_a.mem_rvalid = 1'b1;
        @(negedge clk); bus_a.mem_rvalid = 1'b0;
        chk("rw_no_resp", 32'(bus_a.resp_valid), 32'd0);
        @(negedge clk);
        chk("rw_no_resp2", 32'(bus_a.resp_valid), 32'd0);
        chk("rw_ready", 32'(bus_a.req_ready), 32'd1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator between the pipeline MEM stage and the word-organised data memory.
- Accepts one byte, half or word access at a time and checks alignment.
- Stores: generates the word address, the 4-bit byte_select and the lane-replicated write data.
- Loads: extracts the addressed lane and sign/zero-extends it, with a valid/ready request handshake, a response strobe and a timeout watchdog.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in ISSUE+WAIT_R before aborting with timeout (range 1..65535)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 forces the reset state immediately
req_valid  input  1  pipeline presents an access
req_ready  output  1  LSU can accept (high only in IDLE)
req_op  input  4  [3]=store, [2]=unsigned (loads only), [1:0]=size 00 byte, 01 half, 10 word, 11 treated as word
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
req_pc  input  32  PC of the access, carried to the response
mem_valid  output  1  memory request active
mem_ready  input  1  memory accepts the request this cycle
mem_we  output  1  1=write
mem_addr  output  32  {addr[31:2],2'b00}
mem_byte_select  output  4  byte-lane enables (writes only; 4'b0000 on reads)
mem_wdata  output  32  lane-replicated store data
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word
resp_valid  output  1  one-cycle completion strobe
resp_data  output  32  extended load data (0 for stores and faults)
resp_exc  output  2  00 ok, 01 misaligned load, 10 misaligned store, 11 timeout
resp_pc  output  32  latched req_pc

Behaviour:
- Reset: state=IDLE, every output 0 except req_ready=1, timeout counter 0. Reset asserted mid-transaction aborts it with no response; mem_valid drops asynchronously.
- FSM states: IDLE, ISSUE, WAIT_R, RESP.
- IDLE: req_ready=1. On req_valid:
  - Latch op/addr/wdata/pc and clear the counter.
  - Misaligned access goes to RESP with exc 01 (load) or 10 (store). Misaligned means half with addr[0]=1, or word/size11 with addr[1:0]!=0.
  - Aligned access goes to ISSUE.
- ISSUE: mem_valid=1 with mem_we/mem_addr/mem_byte_select/mem_wdata stable until mem_ready.
  - On mem_ready, a store goes to RESP (exc 00) and a load goes to WAIT_R.
- WAIT_R: mem_valid=0. mem_rvalid is sampled only in this state, so an rvalid in the ISSUE/accept cycle is ignored. On mem_rvalid, capture the extracted data and go to RESP.
- Timeout:
  - The counter increments every cycle in ISSUE or WAIT_R.
  - When counter==TIMEOUT_CYCLES-1 and that cycle does not complete, go to RESP with exc 11, resp_data 0, mem_valid deasserted.
  - Completion on that same cycle wins over timeout.
- RESP: resp_valid=1 for exactly one cycle with data/exc/pc held; next state IDLE. resp_* hold their values until the next RESP.
- Byte select (b=addr[1:0]):
  - byte: 1<<b
  - half: addr[1]=0 gives 0011, addr[1]=1 gives 1100
  - word: 1111
- mem_wdata: byte is {4{wdata[7:0]}}, half is {2{wdata[15:0]}}, word is wdata.
- Load extract:
  - byte: rdata[8b+7:8b]
  - half: rdata[31:16] if addr[1] else rdata[15:0]
  - extension is sign unless op[2]=1, then zero; op[2] is ignored for word.
- Minimum latency, counted from the accept cycle (=0):
  - misaligned: resp at 1
  - store with immediate ready: resp at 2
  - load with immediate ready and rvalid next cycle: resp at 3
- No new request is accepted until the cycle after RESP.

Test Plan:
- Store byte: op=1000, addr=0x00000006, wdata=0x000000AB, mem_ready=1 -> mem_byte_select=0100, mem_addr=0x00000004, mem_wdata=0xABABABAB, mem_we=1; resp_valid at cycle 2, exc 00.
- Signed/unsigned half: mem_rdata=0x8001F00F. op=0001 addr=0x10 -> resp_data=0xFFFFF00F. op=0101 addr=0x12 -> resp_data=0x00008001, resp at cycle 3.
- Misaligned: op=0010 addr=0x0000000A -> no mem_valid, resp_valid at cycle 1, exc 01. op=1001 addr=0x1 -> exc 10.
- Backpressure: mem_ready low 5 cycles then high, load byte LBU addr=0x3, rdata=0xC3000000 -> mem_valid/addr stable throughout, resp_data=0x000000C3.
- Timeout: TIMEOUT_CYCLES=4, mem_ready stuck 0 -> mem_valid high 4 cycles then low; resp_valid with exc 11, resp_data 0, req_ready=1 the next cycle.
- Reset mid-WAIT_R: drive reset=0 asynchronously -> mem_valid=0 and req_ready=1 immediately; no resp_valid; a later mem_rvalid pulse is ignored.
